// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding definitions: instruction formats, base opcodes and
// the immediate range check used by the encoder pipeline.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] OP     = 7'h33;

  // True when the immediate cannot be represented in the given format.
  function automatic logic imm_range_err(input logic [2:0] fmt, input logic [31:0] imm);
    logic err;
    err = 1'b1;
    case (fmt)
      FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        err = |imm[11:0];
      FMT_R:        err = 1'b0;
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters fields and immediate bits into the
// RV32I I/S/B/U/J/R layouts; errored words are forced to zero.
module imm_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  always_comb begin
    instr_o = '0;
    err_o   = imm_range_err(fmt_i, imm_i);
    case (fmt_i)
      FMT_I: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      default: instr_o = '0;
    endcase
    if (err_o) instr_o = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: stage 1 range-checks the
// immediate, stage 2 packs the word; saturating count of errored deliveries.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  logic        s1_valid_q, s1_valid_d;
  logic        s1_err_q, s1_err_d;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;

  logic                     s2_valid_q, s2_valid_d;
  logic [31:0]              instr_q, instr_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        s1_adv, s2_adv, s1_load;
  logic [31:0] pack_instr;
  logic        pack_err;

  // in_ready is combinational from out_ready; there is no skid buffer.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    if (s1_adv) s1_valid_d = in_valid;
    if (s1_load) s1_err_d = imm_range_err(in_fmt, in_imm);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_fmt_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_imm_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      if (s1_load) begin
        s1_fmt_q    <= in_fmt;
        s1_opcode_q <= in_opcode;
        s1_rd_q     <= in_rd;
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_funct3_q <= in_funct3;
        s1_funct7_q <= in_funct7;
        s1_imm_q    <= in_imm;
      end
    end
  end

  imm_pack u_pack (
    .fmt_i    (s1_fmt_q),
    .opcode_i (s1_opcode_q),
    .rd_i     (s1_rd_q),
    .rs1_i    (s1_rs1_q),
    .rs2_i    (s1_rs2_q),
    .funct3_i (s1_funct3_q),
    .funct7_i (s1_funct7_q),
    .imm_i    (s1_imm_q),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  always_comb begin
    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = pack_instr;
        err_d   = s1_err_q || pack_err;
      end
    end
    if (s2_valid_q && out_ready && err_q && !(&cnt_q)) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: format encodings, error handling,
// counter saturation, backpressure and mid-stream reset.
module tb_instr_encoder;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ERR_CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Offers one word into an empty pipeline and returns what is delivered.
  task automatic send_get(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm,
                          output logic [31:0] instr, output logic err, output bit ok);
    ok = 1'b0; instr = '0; err = 1'b0;
    @(negedge clk);
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (out_valid) begin
        instr = out_instr; err = out_err; ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr got=%h exp=0", out_instr); else passed++;
    checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", out_err); else passed++;
    checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_i_type();
    @(negedge clk);
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL i_latency_early got=%b exp=0", out_valid); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL i_latency_valid got=%b exp=1", out_valid); else passed++;
    checks++; if (out_instr !== 32'h00500093) $display("FAIL i_instr got=%h exp=00500093", out_instr); else passed++;
    checks++; if (out_err !== 1'b0) $display("FAIL i_err got=%b exp=0", out_err); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(FMT_S, STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drive(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0020A423)
      $display("FAIL b2b_s got=%b/%h exp=1/0020A423", out_valid, out_instr); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFE000EE3)
      $display("FAIL b2b_b got=%b/%h exp=1/FE000EE3", out_valid, out_instr); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_j_u_r();
    logic [31:0] instr; logic err; bit ok;
    send_get(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, instr, err, ok);
    checks++; if (!ok || instr !== 32'h001000EF || err !== 1'b0)
      $display("FAIL jal got=%0d/%h/%b exp=1/001000EF/0", ok, instr, err); else passed++;
    send_get(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, instr, err, ok);
    checks++; if (!ok || instr !== 32'h123452B7 || err !== 1'b0)
      $display("FAIL lui got=%0d/%h/%b exp=1/123452B7/0", ok, instr, err); else passed++;
    send_get(FMT_R, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, instr, err, ok);
    checks++; if (!ok || instr !== 32'h402081B3 || err !== 1'b0)
      $display("FAIL r_sub got=%0d/%h/%b exp=1/402081B3/0", ok, instr, err); else passed++;
    checks++; if (err_count !== 8'd0) $display("FAIL no_err_count got=%0d exp=0", err_count); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] instr; logic err; bit ok;
    send_get(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, instr, err, ok);
    checks++; if (!ok || instr !== 32'h0 || err !== 1'b1)
      $display("FAIL err_i_range got=%0d/%h/%b exp=1/00000000/1", ok, instr, err); else passed++;
    checks++; if (err_count !== 8'd1) $display("FAIL err_count_1 got=%0d exp=1", err_count); else passed++;
    send_get(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, instr, err, ok);
    checks++; if (!ok || err !== 1'b1) $display("FAIL err_b_odd got=%0d/%b exp=1/1", ok, err); else passed++;
    checks++; if (err_count !== 8'd2) $display("FAIL err_count_2 got=%0d exp=2", err_count); else passed++;
    send_get(3'd7, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, instr, err, ok);
    checks++; if (!ok || err !== 1'b1 || instr !== 32'h0)
      $display("FAIL err_fmt7 got=%0d/%b/%h exp=1/1/00000000", ok, err, instr); else passed++;
    checks++; if (err_count !== 8'd3) $display("FAIL err_count_3 got=%0d exp=3", err_count); else passed++;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    drive(3'd7, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'd255) $display("FAIL err_count_sat got=%0d exp=255", err_count); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q [4];
    int sent, rcv, stall_left;
    bit first_seen, saw_full, in_fire;
    exp_q[0] = 32'h00100093; exp_q[1] = 32'h00200113;
    exp_q[2] = 32'h00300193; exp_q[3] = 32'h00400213;
    sent = 0; rcv = 0; stall_left = 0; first_seen = 0; saw_full = 0;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      @(negedge clk);
      if (sent < 4) begin
        drive(FMT_I, OP_IMM, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent + 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && !first_seen) begin first_seen = 1; stall_left = 3; end
      out_ready = (stall_left == 0);
      #1;
      if (!in_ready) saw_full = 1;
      if (!out_ready) begin
        checks++; if (out_valid !== 1'b1 || out_instr !== exp_q[rcv])
          $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_instr, exp_q[rcv]); else passed++;
        stall_left--;
      end
      in_fire = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++; if (out_instr !== exp_q[rcv] || out_err !== 1'b0)
          $display("FAIL bp_word%0d got=%h exp=%h", rcv, out_instr, exp_q[rcv]); else passed++;
        rcv++;
      end
      @(posedge clk);
      if (in_fire) sent++;
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcv != 4) $display("FAIL bp_count got=%0d exp=4", rcv); else passed++;
    checks++; if (saw_full != 1) $display("FAIL bp_in_ready_low got=%0d exp=1", saw_full); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    @(negedge clk);
    drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || err_count !== 8'd255)
      $display("FAIL rst_pre got=%b/%0d exp=1/255", out_valid, err_count); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (err_count !== 8'd0) $display("FAIL rst_err_count got=%0d exp=0", err_count); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_after_early got=%b exp=0", out_valid); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00200113)
      $display("FAIL rst_after_word got=%b/%h exp=1/00200113", out_valid, out_instr); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_back_to_back();
    test_j_u_r();
    test_errors();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
